freq_meas_ctrl: RTL and testbench

Measurement sequencer for the frequency-counter datapath. Opens and closes the counting gate of `freq_counter` via clear/enable strobes, waits for the input synchronizer to drain, and latches the count into a stable result register for `BinaryToBCD` and the display path. Selects one of three gate lengths (decades) automatically so the result stays within the 12-bit counter range, and reports the decade for decimal-point placement.

---
 rtl/freq_meas_ctrl.sv | 131 +++++++++++++
 tb/tb_freq_meas_ctrl.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/freq_meas_ctrl.sv
// Frequency-counter measurement sequencer: gate control, count latch, decade select.
// Define FREQ_AUTORANGE_EN for automatic decade selection; otherwise range_sel fixes the gate.
module freq_meas_ctrl #(
  parameter int CNT_W         = 12,
  parameter int GATE_BASE     = 1_000_000,
  parameter int SETTLE_CYCLES = 2,
  parameter int HOLD_CYCLES   = 25_000_000,
  parameter int LOW_THRESH    = 300
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic             run,
  input  logic [1:0]       range_sel,
  input  logic [CNT_W-1:0] cnt_val,
  input  logic             cnt_ovf,
  output logic             cnt_clr,
  output logic             cnt_en,
  output logic [CNT_W-1:0] freq,
  output logic [1:0]       range,
  output logic             ovf_flag,
  output logic             valid,
  output logic             busy
);

  localparam int GW  = $clog2(100*GATE_BASE+1);
  localparam int SW  = $clog2(SETTLE_CYCLES+1);
  localparam int HW  = $clog2(HOLD_CYCLES+1);
  localparam int TW0 = (GW > SW) ? GW : SW;
  localparam int TW  = (TW0 > HW) ? TW0 : HW;

  localparam logic [TW-1:0] G0   = TW'(100*GATE_BASE);
  localparam logic [TW-1:0] G1   = TW'(10*GATE_BASE);
  localparam logic [TW-1:0] G2   = TW'(GATE_BASE);
  localparam logic [TW-1:0] SETL = TW'(SETTLE_CYCLES);
  localparam logic [TW-1:0] HLD  = TW'(HOLD_CYCLES);
  localparam logic [TW-1:0] ONE  = TW'(1);

  localparam logic [CNT_W-1:0] LOW = CNT_W'(LOW_THRESH);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_CLEAR  = 3'd1;
  localparam logic [2:0] S_GATE   = 3'd2;
  localparam logic [2:0] S_SETTLE = 3'd3;
  localparam logic [2:0] S_LATCH  = 3'd4;
  localparam logic [2:0] S_HOLD   = 3'd5;

  logic [2:0]    state;
  logic [2:0]    nxt;
  logic [TW-1:0] tmr;
  logic [TW-1:0] tload;
  logic [TW-1:0] glen;
  logic [1:0]    rng_eff;
  logic          up;
  logic          down;

  // Decade that the upcoming gate will use and the range-step decisions
  always_comb begin
`ifdef FREQ_AUTORANGE_EN
    rng_eff = range;
    up      = cnt_ovf && (range != 2'd2);
    down    = !cnt_ovf && (cnt_val < LOW) && (range != 2'd0);
`else
    rng_eff = (range_sel == 2'd3) ? 2'd2 : range_sel;
    up      = 1'b0;
    down    = 1'b0;
`endif
    case (rng_eff)
      2'd0:    glen = G0;
      2'd1:    glen = G1;
      default: glen = G2;
    endcase
  end

  always_comb begin
    nxt = state;
    unique case (state)
      S_IDLE:   if (run) nxt = S_CLEAR;
      S_CLEAR:  nxt = S_GATE;
      S_GATE:   if (tmr <= ONE) nxt = S_SETTLE;
      S_SETTLE: if (tmr <= ONE) nxt = S_LATCH;
      S_LATCH:  nxt = (up || down) ? S_CLEAR : S_HOLD;
      S_HOLD:   if (tmr <= ONE) nxt = run ? S_CLEAR : S_IDLE;
      default:  nxt = S_IDLE;
    endcase
  end

  always_comb begin
    tload = '0;
    unique case (nxt)
      S_GATE:   tload = glen;
      S_SETTLE: tload = SETL;
      S_HOLD:   tload = HLD;
      default:  tload = '0;
    endcase
  end

  // Outputs are decoded from the next state so they line up with the state register
  always_ff @(posedge CLK) begin
    if (reset) begin
      state    <= S_IDLE;
      tmr      <= '0;
      cnt_clr  <= 1'b0;
      cnt_en   <= 1'b0;
      freq     <= '0;
      range    <= 2'd0;
      ovf_flag <= 1'b0;
      valid    <= 1'b0;
      busy     <= 1'b0;
    end else begin
      state   <= nxt;
      tmr     <= (nxt != state) ? tload : tmr - ONE;
      cnt_clr <= (nxt == S_CLEAR);
      cnt_en  <= (nxt == S_GATE);
      busy    <= (nxt != S_IDLE);
      valid   <= 1'b0;
      if (state == S_CLEAR) range <= rng_eff;
      if (state == S_LATCH) begin
        if (up) begin
          range <= range + 2'd1;
        end else if (down) begin
          range <= range - 2'd1;
        end else begin
          freq     <= cnt_ovf ? '1 : cnt_val;
          ovf_flag <= cnt_ovf;
          valid    <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_freq_meas_ctrl.sv
// Directed bench for freq_meas_ctrl with a short gate base.
// Covers the autorange build when FREQ_AUTORANGE_EN is defined, the fixed-range build otherwise.
module tb_freq_meas_ctrl;

  logic        clk;
  logic        reset;
  logic        run;
  logic [1:0]  range_sel;
  logic [11:0] cnt_val;
  logic        cnt_ovf;
  logic        cnt_clr;
  logic        cnt_en;
  logic [11:0] freq;
  logic [1:0]  range;
  logic        ovf_flag;
  logic        valid;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;
  int g;

  freq_meas_ctrl #(
    .CNT_W(12),
    .GATE_BASE(10),
    .SETTLE_CYCLES(2),
    .HOLD_CYCLES(4),
    .LOW_THRESH(300)
  ) dut (
    .CLK(clk),
    .reset(reset),
    .run(run),
    .range_sel(range_sel),
    .cnt_val(cnt_val),
    .cnt_ovf(cnt_ovf),
    .cnt_clr(cnt_clr),
    .cnt_en(cnt_en),
    .freq(freq),
    .range(range),
    .ovf_flag(ovf_flag),
    .valid(valid),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Present a count, then return on the first negedge after the gate closes
  task automatic gate(input logic [11:0] v, input logic o,
                      input bit drop, output int glen);
    bit seen;
    bit done;
    seen = 0;
    done = 0;
    glen = 0;
    cnt_val = v;
    cnt_ovf = o;
    for (int i = 0; i < 3000 && !done; i++) begin
      @(negedge clk);
      if (cnt_en) begin
        seen = 1;
        glen++;
        if (drop && glen == 5) run = 1'b0;
      end else if (seen) begin
        done = 1;
      end
    end
    check("gate_end", {31'd0, done}, 32'd1);
  endtask

  // Settle cycles plus the latch cycle: lands on the first post-latch cycle
  task automatic to_result();
    repeat (3) @(negedge clk);
  endtask

  task automatic pub(input string tag, input logic [11:0] f,
                     input logic [1:0] r, input logic o);
    to_result();
    check({tag, "_valid"}, {31'd0, valid}, 32'd1);
    check({tag, "_freq"}, {20'd0, freq}, {20'd0, f});
    check({tag, "_range"}, {30'd0, range}, {30'd0, r});
    check({tag, "_ovf"}, {31'd0, ovf_flag}, {31'd0, o});
    @(negedge clk);
    check({tag, "_pulse"}, {31'd0, valid}, 32'd0);
  endtask

  task automatic skip(input string tag, input logic [1:0] r);
    to_result();
    check({tag, "_novalid"}, {31'd0, valid}, 32'd0);
    check({tag, "_range"}, {30'd0, range}, {30'd0, r});
    check({tag, "_clr"}, {31'd0, cnt_clr}, 32'd1);
  endtask

  initial begin
    int n;
    reset     = 1'b1;
    run       = 1'b0;
    range_sel = 2'd0;
    cnt_val   = '0;
    cnt_ovf   = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_clr", {31'd0, cnt_clr}, 32'd0);
    check("rst_en", {31'd0, cnt_en}, 32'd0);
    check("rst_freq", {20'd0, freq}, 32'd0);
    check("rst_range", {30'd0, range}, 32'd0);
    check("rst_ovf", {31'd0, ovf_flag}, 32'd0);
    check("rst_valid", {31'd0, valid}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    check("idle_busy", {31'd0, busy}, 32'd0);

`ifdef FREQ_AUTORANGE_EN
    range_sel = 2'd3;
    run = 1'b1;
    @(negedge clk);
    check("start_clr", {31'd0, cnt_clr}, 32'd1);
    check("start_busy", {31'd0, busy}, 32'd1);
    gate(12'd2000, 1'b0, 0, g);
    check("r0_glen", g, 32'd1000);
    pub("r0", 12'd2000, 2'd0, 1'b0);
    gate(12'd4095, 1'b1, 0, g);
    check("ovf0_glen", g, 32'd1000);
    skip("ovf0", 2'd1);
    gate(12'd500, 1'b0, 0, g);
    check("r1_glen", g, 32'd100);
    pub("r1", 12'd500, 2'd1, 1'b0);
    gate(12'd0, 1'b1, 0, g);
    check("ovf1_glen", g, 32'd100);
    skip("ovf1", 2'd2);
    gate(12'd0, 1'b1, 0, g);
    check("ovf2_glen", g, 32'd10);
    pub("ovf2", 12'd4095, 2'd2, 1'b1);
    gate(12'd100, 1'b0, 0, g);
    check("low2_glen", g, 32'd10);
    skip("low2", 2'd1);
    gate(12'd100, 1'b0, 0, g);
    check("low1_glen", g, 32'd100);
    skip("low1", 2'd0);
    gate(12'd1000, 1'b0, 0, g);
    check("back0_glen", g, 32'd1000);
    pub("back0", 12'd1000, 2'd0, 1'b0);
`else
    range_sel = 2'd3;
    run = 1'b1;
    @(negedge clk);
    check("start_clr", {31'd0, cnt_clr}, 32'd1);
    check("start_busy", {31'd0, busy}, 32'd1);
    gate(12'd123, 1'b1, 0, g);
    check("sel3_glen", g, 32'd10);
    pub("sel3", 12'd4095, 2'd2, 1'b1);
    range_sel = 2'd1;
    gate(12'd200, 1'b0, 0, g);
    check("sel1_glen", g, 32'd100);
    pub("sel1", 12'd200, 2'd1, 1'b0);
    range_sel = 2'd0;
    gate(12'd777, 1'b1, 0, g);
    check("sel0o_glen", g, 32'd1000);
    pub("sel0o", 12'd4095, 2'd0, 1'b1);
    gate(12'd2000, 1'b0, 0, g);
    check("sel0_glen", g, 32'd1000);
    pub("sel0", 12'd2000, 2'd0, 1'b0);
`endif

    // Reset in the middle of a long gate
    cnt_val = 12'd2000;
    cnt_ovf = 1'b0;
    n = 0;
    for (int i = 0; i < 3000 && n < 500; i++) begin
      @(negedge clk);
      if (cnt_en) n++;
    end
    check("rst_reach", n, 32'd500);
    reset = 1'b1;
    run   = 1'b0;
    @(negedge clk);
    check("mrst_en", {31'd0, cnt_en}, 32'd0);
    check("mrst_busy", {31'd0, busy}, 32'd0);
    check("mrst_freq", {20'd0, freq}, 32'd0);
    check("mrst_range", {30'd0, range}, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    run = 1'b1;
    @(negedge clk);
    check("restart_clr", {31'd0, cnt_clr}, 32'd1);
    gate(12'd2000, 1'b0, 1, g);
    check("restart_glen", g, 32'd1000);
    pub("restart", 12'd2000, 2'd0, 1'b0);
    repeat (3) @(negedge clk);
    check("stop_busy", {31'd0, busy}, 32'd0);
    check("stop_clr", {31'd0, cnt_clr}, 32'd0);
    repeat (5) @(negedge clk);
    check("stop_idle", {31'd0, busy}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
